// File: rtl/dm_responder_if.sv
// Data-memory port between the core's MEM stage and the data-memory responder.
// The core drives the request side; the responder returns combinational read data.
interface dm_responder_if;
    logic        mem_w;
    logic [3:0]  wea;
    logic [31:0] Addr_in;
    logic [31:0] Data_in;
    logic [31:0] Data_out;

    modport master (
        output mem_w,
        output wea,
        output Addr_in,
        output Data_in,
        input  Data_out
    );

    modport slave (
        input  mem_w,
        input  wea,
        input  Addr_in,
        input  Data_in,
        output Data_out
    );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: word RAM with byte-lane writes plus an IO window
// holding a cycle counter, a byte transmit FIFO and an LED register.
module dm_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    dm_responder_if.slave     dm,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic [15:0]       led
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [5:0] OFF_CYCLE  = 6'h00;
    localparam logic [5:0] OFF_TX     = 6'h01;
    localparam logic [5:0] OFF_STATUS = 6'h02;
    localparam logic [5:0] OFF_LED    = 6'h03;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [31:0]   cycle;

    logic          is_io;
    logic [5:0]    io_off;
    logic [AW-1:0] ram_idx;
    logic          wr_io;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_req;
    logic          push_ok;
    logic          ovf_set;
    logic          ovf_clr;
    logic          led_wr;
    logic [3:0]    status_cnt;
    logic [31:0]   status_word;
    logic          unused_addr;

    assign is_io    = (dm.Addr_in[31:28] == 4'hF);
    assign io_off   = dm.Addr_in[7:2];
    assign ram_idx  = dm.Addr_in[AW+1:2];
    assign unused_addr = ^{dm.Addr_in[27:AW+2], dm.Addr_in[1:0]};

    assign wr_io    = dm.mem_w && is_io;
    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = !empty && tx_ready;
    assign push_req = wr_io && (io_off == OFF_TX) && dm.wea[0];
    // A push into a full FIFO survives only when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = wr_io && (io_off == OFF_STATUS) && dm.wea[0] && dm.Data_in[2];
    assign led_wr   = wr_io && (io_off == OFF_LED);

    assign tx_valid = !empty;
    assign tx_data  = fifo_mem[rd_ptr];

    // Status layout: count in [7:4], bit 3 reserved, then overflow, full, empty.
    assign status_cnt  = 4'(count);
    assign status_word = {24'b0, status_cnt, 1'b0, overflow, full, empty};

    always_ff @(posedge clk) begin
        if (dm.mem_w && !is_io) begin
            for (int i = 0; i < 4; i++) begin
                if (dm.wea[i]) begin
                    mem[ram_idx][8*i +: 8] <= dm.Data_in[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= dm.Data_in[7:0];
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle <= '0;
            led   <= '0;
        end else begin
            cycle <= cycle + 32'd1;
            if (led_wr && dm.wea[0]) begin
                led[7:0] <= dm.Data_in[7:0];
            end
            if (led_wr && dm.wea[1]) begin
                led[15:8] <= dm.Data_in[15:8];
            end
        end
    end

    always_comb begin
        dm.Data_out = '0;
        if (is_io) begin
            case (io_off)
                OFF_CYCLE:  dm.Data_out = cycle;
                OFF_STATUS: dm.Data_out = status_word;
                OFF_LED:    dm.Data_out = {16'b0, led};
                default:    dm.Data_out = '0;
            endcase
        end else begin
            dm.Data_out = mem[ram_idx];
        end
    end

endmodule
